castlab_psum_accumulator: RTL
=============================

CASTLAB_PSUM_ACCUMULATOR -- requirements
Module: castlab_psum_accumulator

Interface
REQ-001 SHALL have parameter OF_NUM, default `CFG_OF_NUM: number of systolic-array output columns.
REQ-002 SHALL have parameter PSUM_BITWIDTH, default 32: incoming psum width, signed.
REQ-003 SHALL have parameter PSUM_FRAC_BIT, default 16: psum fractional bits.
REQ-004 SHALL have parameter OF_BITWIDTH, default `CFG_OF_BITWIDTH: output width, signed.
REQ-005 SHALL have parameter OF_FRAC_BIT, default `CFG_OF_FRAC_BIT: output fractional bits, at most PSUM_FRAC_BIT.
REQ-006 SHALL have parameter DEPTH, default 4: psum entries stored per column.
REQ-007 SHALL have parameter PASS_NUM, default 3: passes accumulated per result, at least 1.
REQ-008 SHALL have port clk  in  1: clock; all state changes on its rising edge.
REQ-009 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-010 SHALL have port acc_start  in  1: pulse that begins a new accumulation.
REQ-011 SHALL have port psum_i_data  in  [OF_NUM][PSUM_BITWIDTH]: psum per column, fed from the array output.
REQ-012 SHALL have port psum_i_valid  in  [OF_NUM]: per-column psum valid.
REQ-013 SHALL have port pass_done  in  1: pulse marking the end of one array pass, driven by the array done flag.
REQ-014 SHALL have port of_o_data  out  [OF_NUM][OF_BITWIDTH]: requantized row of results.
REQ-015 SHALL have port of_o_valid  out  1: of_o_data valid.
REQ-016 SHALL have port of_o_ready  in  1: downstream ready.
REQ-017 SHALL have port acc_busy  out  1: high in every state except IDLE.
REQ-018 SHALL have port acc_done  out  1: one-cycle pulse after the last drain handshake.
REQ-019 SHALL have port acc_ovf  out  1: sticky flag set when a column write is attempted past DEPTH.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-021 SHALL move IDLE->ACCUM on acc_start, clearing pass_cnt, every column write pointer and acc_ovf.
REQ-022 SHALL ignore acc_start in every state except IDLE.
REQ-023 SHALL, in ACCUM and for each column c with psum_i_valid[c] high, write entry wptr[c] and then increment wptr[c]; the write value is psum_i_data[c] when pass_cnt==0, otherwise the stored value plus psum_i_data[c].
REQ-024 SHALL make the ACCUM addition PSUM_BITWIDTH wide, signed, with wrap-around and no saturation.
REQ-025 SHALL, when wptr[c]==DEPTH and psum_i_valid[c] is high, discard the data, hold wptr[c] and set acc_ovf.
REQ-026 SHALL treat a psum_i_valid arriving in the same cycle as pass_done as belonging to the ending pass.
REQ-027 SHALL, on pass_done in ACCUM, reset all wptr[c] to 0; if pass_cnt==PASS_NUM-1 it moves to DRAIN, otherwise it increments pass_cnt.
REQ-028 SHALL ignore pass_done and psum_i_valid outside ACCUM.
REQ-029 SHALL, in DRAIN, present entry rptr of every column on of_o_data with of_o_valid high from the first DRAIN cycle (registered, 1-cycle latency from the pass_done edge).
REQ-030 SHALL hold of_o_data and of_o_valid stable while of_o_valid is high and of_o_ready is low.
REQ-031 SHALL advance rptr on each cycle with of_o_valid and of_o_ready both high; the handshake at rptr==DEPTH-1 moves DRAIN->DONE with of_o_valid dropping.
REQ-032 SHALL assert acc_done for exactly the DONE cycle, then return to IDLE.
REQ-033 SHALL requantize each entry by arithmetic right shift of PSUM_FRAC_BIT-OF_FRAC_BIT, then saturate to the signed OF_BITWIDTH range [-2^(OF_BITWIDTH-1), 2^(OF_BITWIDTH-1)-1].
REQ-034 SHALL output entries that were never written in the current accumulation as 0.

Reset
REQ-035 SHALL, on rst_n low, immediately enter IDLE and clear pass_cnt, wptr, rptr, all entries, of_o_data, of_o_valid, acc_busy, acc_done and acc_ovf to 0.
REQ-036 SHALL, on reset mid-ACCUM or mid-DRAIN, abandon the operation with no acc_done pulse.

Configuration
REQ-037 SHALL, with CASTLAB_PSUM_ROUND_EN defined, add 2^(shift-1) before the REQ-033 shift (round-half-up; no effect when shift is 0); without the macro the shift truncates toward minus infinity.

Verification (PSUM 32/16, OF 16/8, DEPTH=4, PASS_NUM=3, OF_NUM=2)
REQ-038 SHALL cover: 3 passes each writing 0x00010000 to all 4 entries with ready high -> 4 outputs of 0x0300 in 4 consecutive cycles, then an acc_done pulse.
REQ-039 SHALL cover: a single entry accumulating 0x00000180 with PASS_NUM=1 -> output 0x0002 with CASTLAB_PSUM_ROUND_EN defined, 0x0001 without.
REQ-040 SHALL cover: accumulated 0x7FFF0000 and 0x80000000 -> outputs 0x7FFF and 0x8000 respectively (saturation).
REQ-041 SHALL cover: a 5th valid on column 0 within one pass -> acc_ovf=1, entries 0..3 unchanged, column 1 unaffected.
REQ-042 SHALL cover: of_o_ready low for 3 cycles at rptr=1 -> of_o_data held at entry 1 for those cycles, no entry skipped.
REQ-043 SHALL cover: rst_n low during the second DRAIN handshake -> all outputs 0 immediately, acc_done never pulses, and a following acc_start works normally.

Source files
------------

// File: rtl/castlab_psum_accumulator.sv
// Multi-pass partial-sum accumulator: sums PASS_NUM array passes per column entry, then drains requantized rows.
// Define CASTLAB_PSUM_ROUND_EN to round half-up before the requantization shift instead of truncating.
`ifndef CFG_OF_NUM
`define CFG_OF_NUM 2
`endif
`ifndef CFG_OF_BITWIDTH
`define CFG_OF_BITWIDTH 16
`endif
`ifndef CFG_OF_FRAC_BIT
`define CFG_OF_FRAC_BIT 8
`endif

module castlab_psum_accumulator #(
  parameter int OF_NUM        = `CFG_OF_NUM,
  parameter int PSUM_BITWIDTH = 32,
  parameter int PSUM_FRAC_BIT = 16,
  parameter int OF_BITWIDTH   = `CFG_OF_BITWIDTH,
  parameter int OF_FRAC_BIT   = `CFG_OF_FRAC_BIT,
  parameter int DEPTH         = 4,
  parameter int PASS_NUM      = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    acc_start,
  input  logic [OF_NUM-1:0][PSUM_BITWIDTH-1:0]    psum_i_data,
  input  logic [OF_NUM-1:0]                       psum_i_valid,
  input  logic                                    pass_done,
  output logic [OF_NUM-1:0][OF_BITWIDTH-1:0]      of_o_data,
  output logic                                    of_o_valid,
  input  logic                                    of_o_ready,
  output logic                                    acc_busy,
  output logic                                    acc_done,
  output logic                                    acc_ovf
);

  localparam int SHIFT = PSUM_FRAC_BIT - OF_FRAC_BIT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int CW    = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1;
  localparam logic signed [PSUM_BITWIDTH:0] MAXV =
    {{(PSUM_BITWIDTH - OF_BITWIDTH + 2){1'b0}}, {(OF_BITWIDTH - 1){1'b1}}};
  localparam logic signed [PSUM_BITWIDTH:0] MINV = ~MAXV;
`ifdef CASTLAB_PSUM_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [PSUM_BITWIDTH:0] RND =
    (SHIFT > 0) ? ({{PSUM_BITWIDTH{1'b0}}, 1'b1} << RND_POS) : '0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                                             state;
  logic [CW-1:0]                                      pass_cnt;
  logic [OF_NUM-1:0][PW-1:0]                          wptr;
  logic [AW-1:0]                                      rptr;
  logic [OF_NUM-1:0][DEPTH-1:0][PSUM_BITWIDTH-1:0]    mem;

  logic [OF_NUM-1:0]                                  wr_ok;
  logic [AW-1:0]                                      waddr   [OF_NUM];
  logic signed [PSUM_BITWIDTH-1:0]                    wr_val  [OF_NUM];
  logic signed [PSUM_BITWIDTH-1:0]                    head_val[OF_NUM];

  // Widened by one bit so the rounding offset can never overflow before the shift.
  function automatic logic signed [OF_BITWIDTH-1:0] requant(input logic signed [PSUM_BITWIDTH-1:0] v);
    logic signed [PSUM_BITWIDTH:0] ext;
    logic signed [PSUM_BITWIDTH:0] sh;
    ext = {v[PSUM_BITWIDTH-1], v};
`ifdef CASTLAB_PSUM_ROUND_EN
    ext = ext + RND;
`endif
    sh = ext >>> SHIFT;
    if (sh > MAXV)      requant = MAXV[OF_BITWIDTH-1:0];
    else if (sh < MINV) requant = MINV[OF_BITWIDTH-1:0];
    else                requant = sh[OF_BITWIDTH-1:0];
  endfunction

  // head_val forwards a same-cycle write to entry 0 so the first drained row is current.
  always_comb begin
    for (int c = 0; c < OF_NUM; c++) begin
      wr_ok[c]    = (state == ACCUM) && psum_i_valid[c] && (wptr[c] != PW'(DEPTH));
      waddr[c]    = wr_ok[c] ? wptr[c][AW-1:0] : '0;
      wr_val[c]   = $signed(psum_i_data[c]);
      if (pass_cnt != '0)
        wr_val[c] = $signed(mem[c][waddr[c]]) + $signed(psum_i_data[c]);
      head_val[c] = $signed(mem[c][0]);
      if (wr_ok[c] && (waddr[c] == '0))
        head_val[c] = wr_val[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pass_cnt   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      mem        <= '0;
      of_o_data  <= '0;
      of_o_valid <= 1'b0;
      acc_busy   <= 1'b0;
      acc_done   <= 1'b0;
      acc_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_start) begin
            state    <= ACCUM;
            acc_busy <= 1'b1;
            pass_cnt <= '0;
            wptr     <= '0;
            rptr     <= '0;
            mem      <= '0;
            acc_ovf  <= 1'b0;
          end
        end
        ACCUM: begin
          for (int c = 0; c < OF_NUM; c++) begin
            if (psum_i_valid[c]) begin
              if (wr_ok[c]) begin
                mem[c][waddr[c]] <= wr_val[c];
                wptr[c]          <= wptr[c] + PW'(1);
              end else begin
                acc_ovf <= 1'b1;
              end
            end
          end
          if (pass_done) begin
            wptr <= '0;
            if (pass_cnt == CW'(PASS_NUM - 1)) begin
              state      <= DRAIN;
              rptr       <= '0;
              of_o_valid <= 1'b1;
              for (int c = 0; c < OF_NUM; c++)
                of_o_data[c] <= requant(head_val[c]);
            end else begin
              pass_cnt <= pass_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (of_o_ready) begin
            if (rptr == AW'(DEPTH - 1)) begin
              state      <= DONE;
              of_o_valid <= 1'b0;
              acc_done   <= 1'b1;
            end else begin
              rptr <= rptr + AW'(1);
              for (int c = 0; c < OF_NUM; c++)
                of_o_data[c] <= requant($signed(mem[c][rptr + AW'(1)]));
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          acc_done <= 1'b0;
          acc_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
